// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encodings and parameter limits for the shift/LFSR register
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SER_R = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_SER_L = 2'b11
  } mode_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/parity_feedback.sv
// rtl/parity_feedback.sv - XOR-reduction of the masked register bits (LFSR feedback)
module parity_feedback #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] mask,
  output logic             fb
);

  assign fb = ^(q & mask);

endmodule

// File: rtl/param_shift_lfsr.sv
// rtl/param_shift_lfsr.sv - parameterised register: hold, serial right/left, LFSR right
module param_shift_lfsr
  import shift_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS    = 4'b0011,
  parameter logic [WIDTH-1:0] SEED    = 4'b0001,
  parameter bit             AUTO_SEED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             shift_en,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             word_valid,
  output logic             lockup
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("param_shift_lfsr: WIDTH %0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  if (SEED == '0) begin : g_bad_seed
    $error("param_shift_lfsr: SEED must be nonzero");
  end
  if ($bits(TAPS) != WIDTH) begin : g_bad_taps
    $error("param_shift_lfsr: TAPS width does not match WIDTH");
  end

  mode_e            m;
  logic             fb;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] q_next;
  logic             wv_next;
  logic             lock_next;

  assign m = mode_e'(mode);

  parity_feedback #(.WIDTH(WIDTH)) u_fb (
    .q    (q),
    .mask (TAPS),
    .fb   (fb)
  );

  always_comb begin
    q_next    = q;
    cnt_next  = cnt;
    wv_next   = 1'b0;
    lock_next = lockup;
    if (load) begin
      q_next    = d;
      cnt_next  = '0;
      lock_next = 1'b0;
    end else if (shift_en) begin
      unique case (m)
        MODE_SER_R, MODE_SER_L: begin
          q_next = (m == MODE_SER_R) ? {serial_in, q[WIDTH-1:1]} : {q[WIDTH-2:0], serial_in};
          // the shift completing a word wraps the counter and raises word_valid with it
          if (cnt == CW'(WIDTH - 1)) begin
            cnt_next = '0;
            wv_next  = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        MODE_LFSR: begin
          cnt_next = '0;
          if (q == '0) begin
            if (AUTO_SEED) q_next = SEED;
            else           lock_next = 1'b1;
          end else begin
            q_next = {fb, q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
      lockup     <= 1'b0;
    end else begin
      q          <= q_next;
      cnt        <= cnt_next;
      word_valid <= wv_next;
      lockup     <= lock_next;
    end
  end

  assign serial_out = (m == MODE_SER_L) ? q[WIDTH-1] : q[0];

endmodule
